if_fetch: RTL
=============

Name: if_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the synchronous instruction memory, which has a fixed 1-cycle read latency.
- Presents {instruction, PC} to IF/ID.
- Handles stalls from the hazard unit with a one-entry hold register, so memory is not re-read during a stall.
- Handles control-flow redirects, squashing the wrong-path instruction to NOP.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'hFC000000, instruction emitted when no valid instruction exists
PC_INC, 32'h00000001, sequential PC increment (word-addressed instruction memory)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
data_hazard  input  1  stall request from hazard unit
PC_hazard  input  1  stall request from hazard unit
pop_haz  input  1  stall request (stack pop hazard)
redirect_valid  input  1  branch/jump/return resolved taken this cycle
redirect_pc  input  32  redirect target address
imem_addr  output  32  instruction memory read address
imem_rd_en  output  1  instruction memory read enable
imem_rdata  input  32  read data; valid the cycle after an enabled read
instruction_out  output  32  instruction to IF/ID instruction_in
PC_out  output  32  address of instruction_out, to IF/ID PC_in

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- stall = data_hazard | PC_hazard | pop_haz.
- Internal registers:
  - fetch_pc: address to read this cycle.
  - out_pc: address of the instruction returning this cycle.
  - out_valid.
  - hold_valid, hold_instr.
- Reset, asynchronous, effective immediately:
  - fetch_pc=RESET_PC, out_pc=RESET_PC, out_valid=0, hold_valid=0, hold_instr=NOP_INSTR.
  - imem_rd_en is forced 0 while rst=1.
  - Outputs during reset: instruction_out=NOP_INSTR, PC_out=RESET_PC, imem_addr=RESET_PC.
- Combinational outputs:
  - PC_out = out_pc.
  - instruction_out = NOP_INSTR if (!out_valid | redirect_valid); else hold_instr if hold_valid; else imem_rdata.
- Per-cycle priority is redirect > stall > run. Reset overrides everything.
- Redirect (redirect_valid=1, regardless of stall):
  - imem_addr=redirect_pc, imem_rd_en=1.
  - Next: fetch_pc=redirect_pc+PC_INC, out_pc=redirect_pc, out_valid=1, hold_valid=0.
  - The instruction on the outputs this cycle is squashed to NOP_INSTR.
- Stall (stall=1, redirect_valid=0):
  - imem_rd_en=0, imem_addr=fetch_pc.
  - fetch_pc and out_pc hold.
  - If out_valid & !hold_valid: hold_instr<=imem_rdata, hold_valid<=1 (capture on the first stall cycle only).
  - Outputs stay constant for the whole stall.
- Run (no stall, no redirect):
  - imem_addr=fetch_pc, imem_rd_en=1.
  - Next: fetch_pc=fetch_pc+PC_INC, out_pc=fetch_pc, out_valid=1, hold_valid=0.
- Latency: an instruction appears on instruction_out exactly 1 cycle after its address is presented with imem_rd_en=1, absent stalls.
- Stall release: on the first non-stall cycle, IF/ID captures the held instruction; the next sequential address is read in that same cycle.
- Stall lasting 1 cycle or N cycles: identical output sequence; no instruction is duplicated or dropped.
- First cycle after reset release: out_valid=0, so instruction_out=NOP_INSTR and PC_out=RESET_PC; RESET_PC is read that cycle.
- Stall asserted in the first cycle after reset: out_valid=0, so nothing is captured; NOP_INSTR is held.
- Redirect while hold_valid=1: the hold entry is discarded.
- Redirect to the current fetch_pc is legal and behaves normally.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFF+1 wraps to 32'h00000000 with no flag.
- Reset asserted mid-stall or mid-redirect: all state is cleared immediately; fetch restarts at RESET_PC after release.

Test Plan:
- Reset release, no stalls, memory holds mem[a]=a|32'hA0000000 → cycle 1 outputs NOP_INSTR/PC 0; cycles 2..5 output A0000000..A0000003 with PC_out 0..3; imem_addr 0,1,2,3,4.
- data_hazard high 3 cycles while PC_out=2 → instruction_out=A0000002, PC_out=2 for all 3 cycles; imem_rd_en=0; after release PC_out 3,4 follow, with no duplicate and no gap.
- redirect_valid with redirect_pc=32'h40 while PC_out=5 → that cycle instruction_out=FC000000; next cycle PC_out=32'h40, instruction A0000040; then PC_out=32'h41.
- redirect_valid and pop_haz asserted together during an active hold → redirect wins; hold is discarded; next PC_out=redirect_pc.
- Redirect to 32'hFFFFFFFF → PC_out sequence FFFFFFFF, 00000000, 00000001.
- rst pulsed asynchronously between clock edges during a stall → outputs immediately NOP_INSTR/RESET_PC, imem_rd_en=0; fetch resumes at 0 after release.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency instruction memory and
// feeds {instruction, PC} to IF/ID, with a one-entry hold buffer for stalls and redirect squash.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hFC00_0000,
    parameter logic [31:0] PC_INC    = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        PC_hazard,
    input  logic        pop_haz,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out
);

    logic        stall;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    assign stall = data_hazard | PC_hazard | pop_haz;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        imem_addr    = fetch_pc_q;
        imem_rd_en   = 1'b0;

        if (redirect_valid) begin
            imem_addr    = redirect_pc;
            imem_rd_en   = 1'b1;
            fetch_pc_d   = redirect_pc + PC_INC;
            out_pc_d     = redirect_pc;
            out_valid_d  = 1'b1;
            hold_valid_d = 1'b0;
        end else if (stall) begin
            // Memory output is only valid for one cycle, so capture it on the first stall cycle.
            if (out_valid_q && !hold_valid_q) begin
                hold_instr_d = imem_rdata;
                hold_valid_d = 1'b1;
            end
        end else begin
            imem_rd_en   = 1'b1;
            fetch_pc_d   = fetch_pc_q + PC_INC;
            out_pc_d     = fetch_pc_q;
            out_valid_d  = 1'b1;
            hold_valid_d = 1'b0;
        end

        if (rst) begin
            imem_addr  = RESET_PC;
            imem_rd_en = 1'b0;
        end
    end

    always_comb begin
        if (!out_valid_q || redirect_valid) begin
            instruction_out = NOP_INSTR;
        end else if (hold_valid_q) begin
            instruction_out = hold_instr_q;
        end else begin
            instruction_out = imem_rdata;
        end
    end

    assign PC_out = out_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            out_pc_q     <= RESET_PC;
            out_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule
